// File: rtl/ppu_vram_port.sv
// ppu_vram_port: CPU/PPU shared VRAM access port.
// Provides the $2000 increment bit, the $2006 two-write address latch, buffered
// $2007 access, nametable mirroring, a 32-entry internal palette and fixed-priority
// PPU/CPU arbitration onto one synchronous memory with configurable read latency.
module ppu_vram_port #(
    parameter int unsigned ADDR_W     = 14,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned PAL_W      = 6,
    parameter int unsigned MIRROR     = 1,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        cpu_reg_sel,
    input  logic [DATA_W-1:0] cpu_data_in,
    input  logic              cpu_write_en,
    input  logic              cpu_read_en,
    input  logic              status_read,
    output logic [DATA_W-1:0] cpu_data_out,
    output logic              busy,
    input  logic              ppu_req,
    input  logic [ADDR_W-1:0] ppu_addr,
    output logic [DATA_W-1:0] ppu_data,
    output logic              ppu_valid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, PPU_RD, CPU_WR, CPU_RD} state_t;

    localparam logic [ADDR_W-1:0] NT_BASE  = ADDR_W'(16'h2000);
    localparam logic [ADDR_W-1:0] PAL_BASE = ADDR_W'(16'h3F00);
    localparam logic [ADDR_W-1:0] CHR_OFS  = ADDR_W'(16'h1000);
    localparam logic [2:0]        LAT      = 3'(RD_LATENCY);

    // Nametable mirroring: 0x3000-0x3EFF aliases 0x2000-0x2EFF, CHR passes through.
    function automatic logic [ADDR_W-1:0] fold(input logic [ADDR_W-1:0] a);
        logic [1:0] t;
        logic [1:0] p;
        t = a[11:10];
        case (MIRROR)
            0:       p = {1'b0, t[1]};
            1:       p = {1'b0, t[0]};
            2:       p = 2'b00;
            3:       p = 2'b01;
            default: p = t;
        endcase
        if (a < NT_BASE) return a;
        return ADDR_W'({2'b10, p, a[9:0]});
    endfunction

    // Sprite backdrop entries 0x10/0x14/0x18/0x1C alias the background ones.
    function automatic logic [4:0] pal_idx(input logic [ADDR_W-1:0] a);
        logic [4:0] i;
        i = a[4:0];
        if (i[4] && (i[1:0] == 2'b00)) i[4] = 1'b0;
        return i;
    endfunction

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              free, issue_ppu, issue_cpu;

    logic [ADDR_W-1:0] vaddr;
    logic              w_tog, inc32;
    logic [DATA_W-1:0] rbuf;
    logic [PAL_W-1:0]  palette [32];

    logic              cpu_q, cpu_we_q;
    logic [ADDR_W-1:0] cpu_addr_q;
    logic [DATA_W-1:0] cpu_wdata_q;
    logic              out_pend, out_pal;
    logic [4:0]        out_idx;

    logic              ppu_pend, ppu_pal_q;
    logic [ADDR_W-1:0] ppu_pend_addr;
    logic [4:0]        ppu_pal_idx;

    logic [ADDR_W-1:0] op_addr;
    logic [DATA_W-1:0] op_wdata;

    logic              reg7_wr, reg7_rd, vaddr_pal, cpu_acc_mem, cpu_waiting, cpu_want;
    logic              ppu_live, ppu_want, cpu_want_we;
    logic [ADDR_W-1:0] acc_addr, ppu_want_addr, cpu_want_addr, step;
    logic [DATA_W-1:0] cpu_want_wdata;

    assign reg7_wr     = cpu_write_en && (cpu_reg_sel == 3'd7) && !cpu_q;
    assign reg7_rd     = cpu_read_en && !cpu_write_en && (cpu_reg_sel == 3'd7) && !cpu_q;
    assign vaddr_pal   = (vaddr >= PAL_BASE);
    assign cpu_acc_mem = reg7_rd || (reg7_wr && !vaddr_pal);
    // Palette reads still refresh the buffer from the nametable underneath.
    assign acc_addr    = fold((reg7_rd && vaddr_pal) ? (vaddr - CHR_OFS) : vaddr);
    assign step        = inc32 ? ADDR_W'(32) : ADDR_W'(1);

    assign ppu_live      = ppu_req && (ppu_addr < PAL_BASE);
    assign ppu_want      = ppu_pend || ppu_live;
    assign ppu_want_addr = ppu_pend ? ppu_pend_addr : fold(ppu_addr);

    assign cpu_waiting    = cpu_q && (state_q != CPU_WR) && (state_q != CPU_RD);
    assign cpu_want       = cpu_waiting || cpu_acc_mem;
    assign cpu_want_we    = cpu_waiting ? cpu_we_q : reg7_wr;
    assign cpu_want_addr  = cpu_waiting ? cpu_addr_q : acc_addr;
    assign cpu_want_wdata = cpu_waiting ? cpu_wdata_q : cpu_data_in;

    assign mem_addr  = op_addr;
    assign mem_wdata = op_wdata;
    assign mem_we    = (state_q == CPU_WR);
    assign mem_re    = ((state_q == PPU_RD) || (state_q == CPU_RD)) && (cnt_q == 3'd0);
    assign busy      = cpu_q;

    // Arbiter state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next grant: memory is free when idle or in the last cycle of an access; PPU wins.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        free      = 1'b0;
        issue_ppu = 1'b0;
        issue_cpu = 1'b0;
        case (state_q)
            PPU_RD, CPU_RD: begin
                if (cnt_q == LAT) free = 1'b1;
                else              cnt_d = cnt_q + 3'd1;
            end
            default: free = 1'b1;
        endcase
        if (free) begin
            cnt_d   = '0;
            state_d = IDLE;
            if (ppu_want) begin
                issue_ppu = 1'b1;
                state_d   = PPU_RD;
            end else if (cpu_want) begin
                issue_cpu = 1'b1;
                state_d   = cpu_want_we ? CPU_WR : CPU_RD;
            end
        end
    end

    // CPU-visible registers: control bit, address latch/pointer and palette writes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            vaddr <= '0;
            w_tog <= 1'b0;
            inc32 <= 1'b0;
            for (int unsigned i = 0; i < 32; i++) palette[i] <= '0;
        end else begin
            if (cpu_write_en && (cpu_reg_sel == 3'd0)) inc32 <= cpu_data_in[2];
            if (cpu_write_en && (cpu_reg_sel == 3'd6)) begin
                if (!w_tog || status_read) begin
                    vaddr <= {cpu_data_in[ADDR_W-9:0], vaddr[7:0]};
                    w_tog <= ~status_read;
                end else begin
                    vaddr <= {vaddr[ADDR_W-1:8], cpu_data_in[7:0]};
                    w_tog <= 1'b0;
                end
            end else if (status_read) begin
                w_tog <= 1'b0;
            end
            if (reg7_wr || reg7_rd) vaddr <= vaddr + step;
            if (reg7_wr && vaddr_pal) palette[pal_idx(vaddr)] <= cpu_data_in[PAL_W-1:0];
        end
    end

    // CPU $2007 tracking: pending access, read data return and buffer refill.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cpu_q        <= 1'b0;
            cpu_we_q     <= 1'b0;
            cpu_addr_q   <= '0;
            cpu_wdata_q  <= '0;
            out_pend     <= 1'b0;
            out_pal      <= 1'b0;
            out_idx      <= '0;
            cpu_data_out <= '0;
            rbuf         <= '0;
        end else begin
            out_pend <= reg7_rd;
            out_pal  <= vaddr_pal;
            out_idx  <= pal_idx(vaddr);
            if (out_pend) cpu_data_out <= out_pal ? DATA_W'(palette[out_idx]) : rbuf;
            if (cpu_acc_mem) begin
                cpu_q       <= 1'b1;
                cpu_we_q    <= reg7_wr;
                cpu_addr_q  <= acc_addr;
                cpu_wdata_q <= cpu_data_in;
            end else if ((state_q == CPU_WR) || ((state_q == CPU_RD) && free)) begin
                cpu_q <= 1'b0;
            end
            if ((state_q == CPU_RD) && free) rbuf <= mem_rdata;
        end
    end

    // PPU fetch path: queue while memory is occupied, answer palette fetches locally.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ppu_pend      <= 1'b0;
            ppu_pend_addr <= '0;
            ppu_pal_q     <= 1'b0;
            ppu_pal_idx   <= '0;
            ppu_valid     <= 1'b0;
            ppu_data      <= '0;
        end else begin
            ppu_valid <= 1'b0;
            if (issue_ppu) begin
                ppu_pend <= 1'b0;
            end else if (ppu_live) begin
                ppu_pend      <= 1'b1;
                ppu_pend_addr <= fold(ppu_addr);
            end
            ppu_pal_q   <= ppu_req && (ppu_addr >= PAL_BASE);
            ppu_pal_idx <= pal_idx(ppu_addr);
            if (ppu_pal_q) begin
                ppu_valid <= 1'b1;
                ppu_data  <= DATA_W'(palette[ppu_pal_idx]);
            end else if ((state_q == PPU_RD) && free) begin
                ppu_valid <= 1'b1;
                ppu_data  <= mem_rdata;
            end
        end
    end

    // Address/data of the access being granted.
    always_ff @(posedge clk) begin
        if (!rst) begin
            op_addr  <= '0;
            op_wdata <= '0;
        end else if (issue_ppu) begin
            op_addr <= ppu_want_addr;
        end else if (issue_cpu) begin
            op_addr  <= cpu_want_addr;
            op_wdata <= cpu_want_wdata;
        end
    end

endmodule

// File: tb/tb_ppu_vram_port.sv
// tb_ppu_vram_port: three instances share one stimulus stream
//   inst 0: MIRROR=1 RD_LATENCY=1, inst 1: MIRROR=0 RD_LATENCY=1, inst 2: MIRROR=1 RD_LATENCY=3
module tb_ppu_vram_port;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  reg_sel = '0;
    logic [7:0]  din = '0;
    logic        we = 1'b0, re = 1'b0, sr = 1'b0, preq = 1'b0;
    logic [13:0] paddr = '0;

    logic [7:0]  dout   [3];
    logic        busy   [3];
    logic [7:0]  pdata  [3];
    logic        pvalid [3];
    logic [13:0] maddr  [3];
    logic [7:0]  mwdata [3];
    logic        mwe    [3];
    logic        mre    [3];
    logic [7:0]  mrdata [3];

    logic [7:0]  mem  [3][16384];
    logic [7:0]  pipe [3][4];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        ppu_vram_port #(
            .ADDR_W(14), .DATA_W(8), .PAL_W(6),
            .MIRROR(g == 1 ? 0 : 1), .RD_LATENCY(g == 2 ? 3 : 1)
        ) u_dut (
            .clk(clk), .rst(rst), .cpu_reg_sel(reg_sel), .cpu_data_in(din),
            .cpu_write_en(we), .cpu_read_en(re), .status_read(sr),
            .cpu_data_out(dout[g]), .busy(busy[g]),
            .ppu_req(preq), .ppu_addr(paddr), .ppu_data(pdata[g]), .ppu_valid(pvalid[g]),
            .mem_addr(maddr[g]), .mem_wdata(mwdata[g]), .mem_we(mwe[g]), .mem_re(mre[g]),
            .mem_rdata(mrdata[g])
        );
    end

    function automatic int lat_of(input int k);
        return (k == 2) ? 3 : 1;
    endfunction

    // Synchronous memory models: data valid RD_LATENCY cycles after the sampling edge.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (mwe[k]) mem[k][maddr[k]] <= mwdata[k];
            pipe[k][0] <= mre[k] ? mem[k][maddr[k]] : 8'hEE;
            for (int j = 1; j < 4; j++) pipe[k][j] <= pipe[k][j-1];
        end
    end

    always_comb begin
        for (int k = 0; k < 3; k++) mrdata[k] = pipe[k][lat_of(k)-1];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20; i++) begin
            if (!busy[0] && !busy[1] && !busy[2]) return;
            tick();
        end
        check("wait_idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic reg_write(input logic [2:0] r, input logic [7:0] d);
        reg_sel = r; din = d; we = 1'b1;
        tick();
        we = 1'b0;
    endtask

    task automatic set_addr(input logic [7:0] hi, input logic [7:0] lo);
        reg_write(3'd6, hi);
        reg_write(3'd6, lo);
    endtask

    // $2007 write to memory; e_v/e_h are expected folded addresses for vertical/horizontal.
    task automatic data_write_check(input string tag, input logic [7:0] d,
                                    input logic [13:0] e_v, input logic [13:0] e_h);
        wait_idle();
        reg_write(3'd7, d);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("%s_addr%0d", tag, k), maddr[k], (k == 1) ? e_h : e_v);
            check($sformatf("%s_we%0d", tag, k), mwe[k], 1);
            check($sformatf("%s_wd%0d", tag, k), mwdata[k], d);
            check($sformatf("%s_busy%0d", tag, k), busy[k], 1);
        end
    endtask

    task automatic data_read();
        wait_idle();
        reg_sel = 3'd7; re = 1'b1;
        tick();
        re = 1'b0;
    endtask

    task automatic data_read_check(input string tag, input logic [13:0] e);
        data_read();
        for (int k = 0; k < 3; k++) begin
            check($sformatf("%s_re%0d", tag, k), mre[k], 1);
            check($sformatf("%s_addr%0d", tag, k), maddr[k], e);
        end
    endtask

    task automatic check_dout(input string tag, input logic [7:0] e);
        for (int k = 0; k < 3; k++) check($sformatf("%s_dout%0d", tag, k), dout[k], e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        tick();
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst_dout%0d", k), dout[k], 0);
            check($sformatf("rst_busy%0d", k), busy[k], 0);
            check($sformatf("rst_pvalid%0d", k), pvalid[k], 0);
            check($sformatf("rst_mre%0d", k), mre[k], 0);
            check($sformatf("rst_mwe%0d", k), mwe[k], 0);
            check($sformatf("rst_maddr%0d", k), maddr[k], 0);
        end
        rst = 1'b1;
        tick();

        // Address latch, and status read resetting the write toggle
        set_addr(8'h21, 8'h08);
        data_write_check("v2108", 8'h55, 14'h2108, 14'h2108);
        reg_write(3'd6, 8'h3F);
        sr = 1'b1; tick(); sr = 1'b0;
        set_addr(8'h23, 8'h00);
        data_write_check("v2300", 8'h66, 14'h2300, 14'h2300);

        // Mirroring
        set_addr(8'h24, 8'h05);
        data_write_check("m2405", 8'hAA, 14'h2405, 14'h2005);
        set_addr(8'h2C, 8'h05);
        data_write_check("m2C05", 8'hAA, 14'h2405, 14'h2405);
        set_addr(8'h30, 8'h05);
        data_write_check("m3005", 8'hAA, 14'h2005, 14'h2005);

        // Preload for arbitration
        set_addr(8'h10, 8'h00);
        data_write_check("pre1000", 8'hC3, 14'h1000, 14'h1000);
        set_addr(8'h20, 8'h00);
        data_write_check("pre2000", 8'h5A, 14'h2000, 14'h2000);

        // Buffered reads
        set_addr(8'h01, 8'h00);
        data_write_check("w11", 8'h11, 14'h0100, 14'h0100);
        data_write_check("w22", 8'h22, 14'h0101, 14'h0101);
        set_addr(8'h01, 8'h00);
        data_read_check("rd0100", 14'h0100); tick(); check_dout("rd1", 8'h00);
        data_read_check("rd0101", 14'h0101); tick(); check_dout("rd2", 8'h11);
        data_read_check("rd0102", 14'h0102); tick(); check_dout("rd3", 8'h22);

        // Increment by 32
        reg_write(3'd0, 8'h04);
        set_addr(8'h01, 8'h00);
        data_read_check("i32a", 14'h0100);
        data_read_check("i32b", 14'h0120);
        reg_write(3'd0, 8'h00);

        // Palette write (aliased), read, PPU palette fetch
        wait_idle();
        set_addr(8'h3F, 8'h10);
        reg_write(3'd7, 8'h3F);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("palw_busy%0d", k), busy[k], 0);
            check($sformatf("palw_mwe%0d", k), mwe[k], 0);
        end
        set_addr(8'h3F, 8'h00);
        data_read_check("palr", 14'h2700);
        tick();
        check_dout("palr", 8'h3F);
        wait_idle();
        preq = 1'b1; paddr = 14'h3F10;
        tick();
        preq = 1'b0;
        for (int k = 0; k < 3; k++) check($sformatf("ppal_n_%0d", k), pvalid[k], 0);
        tick();
        for (int k = 0; k < 3; k++) begin
            check($sformatf("ppal_valid%0d", k), pvalid[k], 1);
            check($sformatf("ppal_data%0d", k), pdata[k], 8'h3F);
            check($sformatf("ppal_mre%0d", k), mre[k], 0);
        end

        // Pointer wrap 0x3FFF -> 0x0000
        set_addr(8'h3F, 8'hFF);
        reg_write(3'd7, 8'h01);
        data_write_check("wrap", 8'h77, 14'h0000, 14'h0000);

        // Simultaneous PPU fetch and CPU read
        set_addr(8'h20, 8'h00);
        wait_idle();
        reg_sel = 3'd7; re = 1'b1; preq = 1'b1; paddr = 14'h1000;
        tick();
        re = 1'b0; preq = 1'b0;
        for (int c = 0; c <= 8; c++) begin
            for (int k = 0; k < 3; k++) begin
                int l;
                l = lat_of(k);
                check($sformatf("arb_busy%0d_c%0d", k, c), busy[k], (c < 2 + 2*l) ? 1 : 0);
                check($sformatf("arb_mre%0d_c%0d", k, c), mre[k], (c == 0 || c == 1 + l) ? 1 : 0);
                check($sformatf("arb_pvalid%0d_c%0d", k, c), pvalid[k], (c == 1 + l) ? 1 : 0);
                if (c == 0) check($sformatf("arb_addr_ppu%0d", k), maddr[k], 14'h1000);
                if (c == 1 + l) begin
                    check($sformatf("arb_addr_cpu%0d", k), maddr[k], 14'h2000);
                    check($sformatf("arb_pdata%0d", k), pdata[k], 8'hC3);
                end
            end
            tick();
        end
        data_read();
        tick();
        check_dout("arb_buf", 8'h5A);

        // Reset in the middle of a CPU read
        data_read();
        check("mid_busy0", busy[0], 1);
        rst = 1'b0;
        tick();
        for (int k = 0; k < 3; k++) begin
            check($sformatf("mid_busy%0d", k), busy[k], 0);
            check($sformatf("mid_mre%0d", k), mre[k], 0);
            check($sformatf("mid_pvalid%0d", k), pvalid[k], 0);
            check($sformatf("mid_dout%0d", k), dout[k], 0);
        end
        rst = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) check($sformatf("post_pvalid%0d", k), pvalid[k], 0);
        set_addr(8'h10, 8'h00);
        data_read();
        wait_idle();
        set_addr(8'h3F, 8'h00);
        data_read();
        tick();
        check_dout("pal_cleared", 8'h00);
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
